// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: writeback ports, read ports, scoreboard
// marking and queries, and the clear handshake. The pipeline side drives
// the master modport; the register file sits on the slave modport.
interface reg_file_param_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
);
  logic            clr_req;
  logic            ready;
  logic            w_en0;
  logic [AW-1:0]   rd0;
  logic [XLEN-1:0] rdv0;
  logic            w_en1;
  logic [AW-1:0]   rd1;
  logic [XLEN-1:0] rdv1;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            sb_set;
  logic [AW-1:0]   sb_rd;
  logic            sb_busy1;
  logic            sb_busy2;

  modport master (
    output clr_req, w_en0, rd0, rdv0, w_en1, rd1, rdv1, rs1, rs2, sb_set, sb_rd,
    input  ready, rs1_data, rs2_data, sb_busy1, sb_busy2
  );

  modport slave (
    input  clr_req, w_en0, rd0, rdv0, w_en1, rd1, rdv1, rs1, rs2, sb_set, sb_rd,
    output ready, rs1_data, rs2_data, sb_busy1, sb_busy2
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised integer register file: two write ports (port 1 = load
// writeback, higher priority), two bypassed combinational read ports, a
// pending-write scoreboard and a sequential clear engine. The storage array
// has no reset; after reset or clr_req it is zeroed one entry per cycle and
// ready stays low until every entry has been written.
module reg_file_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int ZERO_REG = 1
) (
  input logic             clk,
  input logic             rst_n,
  reg_file_param_if.slave bus
);

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

  // Counter is one bit wider than the index so the terminal value never aliases.
  localparam logic [AW:0]     CNT_LAST  = (AW+1)'(NREGS - 1);
  localparam logic [AW:0]     CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]     CNT_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW-1:0]   IDX_ZERO  = {AW{1'b0}};
  localparam logic [XLEN-1:0] WORD_ZERO = {XLEN{1'b0}};
  localparam bit              ZR        = (ZERO_REG != 0);

  state_t          state_r, state_s;
  logic [AW:0]     cnt_r, cnt_s;
  logic            ready_r, ready_s;
  logic            clearing_s;

  logic [XLEN-1:0] mem_r [NREGS];
  logic [NREGS-1:0] sb_r, sb_s;

  logic            w_en0_s, w_en1_s, sb_set_in_s;
  logic [AW-1:0]   rd0_s, rd1_s, rs1_s, rs2_s, sb_rd_s;
  logic [XLEN-1:0] rdv0_s, rdv1_s;
  logic            wr0_s, wr1_s, set_s;

  assign w_en0_s     = bus.w_en0;
  assign w_en1_s     = bus.w_en1;
  assign rd0_s       = bus.rd0;
  assign rd1_s       = bus.rd1;
  assign rdv0_s      = bus.rdv0;
  assign rdv1_s      = bus.rdv1;
  assign rs1_s       = bus.rs1;
  assign rs2_s       = bus.rs2;
  assign sb_set_in_s = bus.sb_set;
  assign sb_rd_s     = bus.sb_rd;

  // Effective write/set strobes: only while ready, never to a hardwired x0.
  assign wr0_s = ready_r & w_en0_s & ~(ZR & (rd0_s == IDX_ZERO));
  assign wr1_s = ready_r & w_en1_s & ~(ZR & (rd1_s == IDX_ZERO));
  assign set_s = ready_r & sb_set_in_s & ~(ZR & (sb_rd_s == IDX_ZERO));

  // FSM state, clear counter and registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_CLEAR;
      cnt_r   <= CNT_ZERO;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ready_r <= ready_s;
    end
  end

  // Next state: walk the counter through the array, restart only from IDLE.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_CLEAR: begin
        cnt_s = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_s = ST_CLEAR;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_CLEAR;
        cnt_s   = CNT_ZERO;
      end
    endcase
    ready_s = (state_s == ST_IDLE);
  end

  // FSM outputs: clear engine active flag.
  always_comb begin
    clearing_s = 1'b0;
    case (state_r)
      ST_CLEAR: clearing_s = 1'b1;
      ST_IDLE:  clearing_s = 1'b0;
      default:  clearing_s = 1'b1;
    endcase
  end

  assign bus.ready = ready_r;

  // Storage array: clear engine, else the two writebacks with port 1 applied last.
  always_ff @(posedge clk) begin
    if (clearing_s) begin
      mem_r[cnt_r[AW-1:0]] <= WORD_ZERO;
    end else begin
      if (wr0_s) mem_r[rd0_s] <= rdv0_s;
      if (wr1_s) mem_r[rd1_s] <= rdv1_s;
    end
  end

  // Scoreboard next value: wiped while clearing; writes clear, set wins on a tie.
  always_comb begin
    sb_s = sb_r;
    if (clearing_s) begin
      sb_s = {NREGS{1'b0}};
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        if ((wr0_s && (rd0_s == AW'(k))) || (wr1_s && (rd1_s == AW'(k)))) begin
          sb_s[k] = 1'b0;
        end else begin
          sb_s[k] = sb_r[k];
        end
        if (set_s && (sb_rd_s == AW'(k))) begin
          sb_s[k] = 1'b1;
        end else begin
          sb_s[k] = sb_s[k];
        end
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_r <= {NREGS{1'b0}};
    end else begin
      sb_r <= sb_s;
    end
  end

  // Bypassed read: x0, then port 1, then port 0, then the array.
  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] idx);
    logic [XLEN-1:0] val;
    if (!ready_r) begin
      val = WORD_ZERO;
    end else if (ZR && (idx == IDX_ZERO)) begin
      val = WORD_ZERO;
    end else if (w_en1_s && (rd1_s == idx)) begin
      val = rdv1_s;
    end else if (w_en0_s && (rd0_s == idx)) begin
      val = rdv0_s;
    end else begin
      val = mem_r[idx];
    end
    return val;
  endfunction

  // Busy unless a same-cycle write retires it without a competing set.
  function automatic logic busy_of(input logic [AW-1:0] idx);
    logic hit, setting;
    hit     = (wr0_s && (rd0_s == idx)) || (wr1_s && (rd1_s == idx));
    setting = set_s && (sb_rd_s == idx);
    return ready_r & sb_r[idx] & ~(hit & ~setting);
  endfunction

  assign bus.rs1_data = read_port(rs1_s);
  assign bus.rs2_data = read_port(rs2_s);
  assign bus.sb_busy1 = busy_of(rs1_s);
  assign bus.sb_busy2 = busy_of(rs2_s);

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param (XLEN = 32, NREGS = 32, ZERO_REG = 1).
// Each cycle: inputs are driven after the falling edge, expected outputs are
// queued, and the queue is compared 1 ns later, before the next rising edge.
module tb_reg_file_param;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  localparam int S_RS1   = 0;
  localparam int S_RS2   = 1;
  localparam int S_BUSY1 = 2;
  localparam int S_BUSY2 = 3;
  localparam int S_READY = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  reg_file_param_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

  reg_file_param #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_RS1:   return bus.rs1_data;
      S_RS2:   return bus.rs2_data;
      S_BUSY1: return {31'd0, bus.sb_busy1};
      S_BUSY2: return {31'd0, bus.sb_busy2};
      default: return {31'd0, bus.ready};
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val(e.tag, observe(e.sel), e.val);
    end
  endtask

  // Compare queued expectations, cross one rising edge, drop pulse inputs.
  task automatic tick();
    #1;
    drain();
    @(posedge clk);
    #1;
    bus.w_en0   = 1'b0;
    bus.w_en1   = 1'b0;
    bus.sb_set  = 1'b0;
    bus.clr_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr0(input logic [AW-1:0] idx, input logic [31:0] val);
    bus.w_en0 = 1'b1;
    bus.rd0   = idx;
    bus.rdv0  = val;
  endtask

  task automatic wr1(input logic [AW-1:0] idx, input logic [31:0] val);
    bus.w_en1 = 1'b1;
    bus.rd1   = idx;
    bus.rdv1  = val;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.clr_req = 1'b0;
    bus.w_en0   = 1'b0;
    bus.rd0     = 5'd0;
    bus.rdv0    = 32'd0;
    bus.w_en1   = 1'b0;
    bus.rd1     = 5'd0;
    bus.rdv1    = 32'd0;
    bus.rs1     = 5'd0;
    bus.rs2     = 5'd0;
    bus.sb_set  = 1'b0;
    bus.sb_rd   = 5'd0;

    // Reset held, then release: 32 edges of clearing.
    @(negedge clk);
    exp_push("rst_ready", S_READY, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.rs1 = 5'd5;
    for (int i = 0; i < NREGS; i++) begin
      exp_push("init_ready_low", S_READY, 32'd0);
      exp_push("init_rs1_zero", S_RS1, 32'd0);
      if (i == 3) bus.clr_req = 1'b1;
      tick();
    end
    bus.rs1 = 5'd5;
    bus.rs2 = 5'd31;
    exp_push("init_ready_high", S_READY, 32'd1);
    exp_push("init_rs1", S_RS1, 32'd0);
    exp_push("init_rs2", S_RS2, 32'd0);
    exp_push("init_busy1", S_BUSY1, 32'd0);
    exp_push("init_busy2", S_BUSY2, 32'd0);
    tick();

    // Port 0 write with same-cycle bypass, then from storage.
    wr0(5'd5, 32'hDEADBEEF);
    bus.rs1 = 5'd5;
    exp_push("x5_bypass", S_RS1, 32'hDEADBEEF);
    tick();
    exp_push("x5_stored", S_RS1, 32'hDEADBEEF);
    tick();

    // Both ports hit x7: port 1 wins for bypass and storage.
    wr0(5'd7, 32'h00000011);
    wr1(5'd7, 32'h00000022);
    bus.rs1 = 5'd7;
    bus.rs2 = 5'd7;
    exp_push("x7_bypass_rs1", S_RS1, 32'h00000022);
    exp_push("x7_bypass_rs2", S_RS2, 32'h00000022);
    tick();
    bus.rs2 = 5'd5;
    exp_push("x7_stored", S_RS1, 32'h00000022);
    exp_push("x5_still", S_RS2, 32'hDEADBEEF);
    tick();

    // Ports to distinct registers, each port bypassing to its own reader.
    wr0(5'd8, 32'h00000033);
    wr1(5'd9, 32'h00000044);
    bus.rs1 = 5'd8;
    bus.rs2 = 5'd9;
    exp_push("x8_bypass", S_RS1, 32'h00000033);
    exp_push("x9_bypass", S_RS2, 32'h00000044);
    tick();
    exp_push("x8_stored", S_RS1, 32'h00000033);
    exp_push("x9_stored", S_RS2, 32'h00000044);
    tick();

    // Writes to x0 are dropped and x0 reads zero.
    wr0(5'd0, 32'hFFFFFFFF);
    wr1(5'd0, 32'hFFFFFFFF);
    bus.rs1 = 5'd0;
    exp_push("x0_bypass", S_RS1, 32'd0);
    tick();
    exp_push("x0_stored", S_RS1, 32'd0);
    tick();

    // Scoreboard: set x9, busy from the next cycle.
    bus.sb_set = 1'b1;
    bus.sb_rd  = 5'd9;
    bus.rs1    = 5'd9;
    bus.rs2    = 5'd9;
    exp_push("sb_set_same_cycle", S_BUSY1, 32'd0);
    tick();
    exp_push("sb9_busy1", S_BUSY1, 32'd1);
    exp_push("sb9_busy2", S_BUSY2, 32'd1);
    tick();
    // Port 1 write retires x9.
    wr1(5'd9, 32'h00000099);
    exp_push("sb9_retire_busy", S_BUSY1, 32'd0);
    exp_push("sb9_retire_data", S_RS1, 32'h00000099);
    tick();
    exp_push("sb9_after_retire", S_BUSY1, 32'd0);
    tick();
    // Set and write together: set wins.
    bus.sb_set = 1'b1;
    bus.sb_rd  = 5'd9;
    tick();
    bus.sb_set = 1'b1;
    bus.sb_rd  = 5'd9;
    wr0(5'd9, 32'h000000AA);
    exp_push("sb9_set_and_write", S_BUSY1, 32'd1);
    tick();
    exp_push("sb9_set_wins", S_BUSY1, 32'd1);
    // Set to x0 is ignored.
    bus.sb_set = 1'b1;
    bus.sb_rd  = 5'd0;
    tick();
    bus.rs2 = 5'd0;
    exp_push("sb0_ignored", S_BUSY2, 32'd0);
    exp_push("sb9_kept", S_BUSY1, 32'd1);
    tick();

    // clr_req from IDLE: 32 cycles of ready = 0, writes dropped.
    wr0(5'd3, 32'h00000055);
    tick();
    bus.rs1 = 5'd3;
    bus.clr_req = 1'b1;
    exp_push("x3_before_clr", S_RS1, 32'h00000055);
    exp_push("ready_at_clr", S_READY, 32'd1);
    tick();
    for (int i = 0; i < NREGS; i++) begin
      bus.rs1 = 5'd3;
      bus.rs2 = 5'd9;
      wr0(5'd4, 32'h00000077);
      bus.sb_set = 1'b1;
      bus.sb_rd  = 5'd4;
      exp_push("clr_ready_low", S_READY, 32'd0);
      exp_push("clr_rs1_zero", S_RS1, 32'd0);
      exp_push("clr_busy2_zero", S_BUSY2, 32'd0);
      tick();
    end
    bus.rs1 = 5'd3;
    bus.rs2 = 5'd4;
    exp_push("clr_done_ready", S_READY, 32'd1);
    exp_push("clr_x3_zero", S_RS1, 32'd0);
    exp_push("clr_x4_dropped", S_RS2, 32'd0);
    exp_push("clr_sb4_empty", S_BUSY2, 32'd0);
    tick();
    bus.rs1 = 5'd9;
    exp_push("clr_sb9_empty", S_BUSY1, 32'd0);
    tick();

    // Reset at clear index 10, then a full clear with clr_req mid-way.
    wr1(5'd20, 32'h000000AB);
    tick();
    bus.rs1 = 5'd20;
    exp_push("x20_before", S_RS1, 32'h000000AB);
    bus.clr_req = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      exp_push("pre_abort_ready", S_READY, 32'd0);
      tick();
    end
    rst_n = 1'b0;
    exp_push("abort_ready", S_READY, 32'd0);
    tick();
    exp_push("abort_hold_ready", S_READY, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      if (i == 5) bus.clr_req = 1'b1;
      exp_push("restart_ready_low", S_READY, 32'd0);
      tick();
    end
    bus.rs1 = 5'd20;
    exp_push("restart_ready_high", S_READY, 32'd1);
    exp_push("restart_x20_zero", S_RS1, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
